// File: rtl/period_decoder_if.sv
// Pulse-train decoder bus: the generator pulse line in, measurement and lock status out.
// Latency: none; this is wiring only. The decoder's outputs are registered one cycle after the pulse.
// Backpressure: none; pulses cannot be stalled, and every pulse is consumed in its own cycle.
//   i_valid        : pulse train, one pulse per high cycle
//   o_period       : last measured period in cycles
//   o_period_valid : one-cycle strobe when o_period updates
//   o_sel          : decoded code of the current or last lock
//   o_locked       : high while locked
//   o_error        : one-cycle strobe on loss of lock
//   o_timeout      : one-cycle strobe when pulses stop
interface period_decoder_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  i_valid;
   logic [DATA_WIDTH-1:0] o_period;
   logic                  o_period_valid;
   logic [1:0]            o_sel;
   logic                  o_locked;
   logic                  o_error;
   logic                  o_timeout;

   // Pulse source / status consumer side
   modport master (
      output i_valid,
      input  o_period, o_period_valid, o_sel, o_locked, o_error, o_timeout
   );

   // Decoder side
   modport slave (
      input  i_valid,
      output o_period, o_period_valid, o_sel, o_locked, o_error, o_timeout
   );
endinterface

// File: rtl/period_decoder.sv
// Measures the spacing of tick-generator pulses, recovers the 2-bit period code and tracks lock.
// Latency: all outputs are registered, so results appear one cycle after the pulse that produced them.
// Backpressure: none; every pulse is measured in the cycle it arrives.
// Ports: clock (rising edge), i_reset (sync, active-high), bus (period_decoder_if.slave:
//        i_valid in; o_period, o_period_valid, o_sel, o_locked, o_error, o_timeout out).
module period_decoder #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned R0            = 3,
   parameter int unsigned R1            = 10,
   parameter int unsigned R2            = 100,
   parameter int unsigned R3            = 5000,
   parameter int unsigned PERIOD_OFFSET = 1,
   parameter int unsigned LOCK_COUNT    = 4
) (
   input  logic            clock,
   input  logic            i_reset,
   period_decoder_if.slave bus
);

   function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                        input int unsigned c, input int unsigned d);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

   // Expected period for each code, and the longest gap tolerated before timing out.
   localparam logic [DATA_WIDTH-1:0] EXP0   = DATA_WIDTH'(R0 + PERIOD_OFFSET);
   localparam logic [DATA_WIDTH-1:0] EXP1   = DATA_WIDTH'(R1 + PERIOD_OFFSET);
   localparam logic [DATA_WIDTH-1:0] EXP2   = DATA_WIDTH'(R2 + PERIOD_OFFSET);
   localparam logic [DATA_WIDTH-1:0] EXP3   = DATA_WIDTH'(R3 + PERIOD_OFFSET);
   localparam logic [DATA_WIDTH-1:0] TLIMIT = DATA_WIDTH'(max4(R0, R1, R2, R3) + PERIOD_OFFSET);

   // One spare value of headroom so the run counter can pass LOCK_COUNT without wrapping
   // (relevant when LOCK_COUNT is 1 and a lock-loss reload already holds a count of 1).
   localparam int unsigned MCW = $clog2(LOCK_COUNT + 2);
   localparam logic [MCW-1:0] LOCK_N = MCW'(LOCK_COUNT);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   state_t                state_q;
   logic [DATA_WIDTH-1:0] cnt_q;
   logic [1:0]            cand_q;
   logic [MCW-1:0]        match_q;
   logic [DATA_WIDTH-1:0] period_q;
   logic                  period_valid_q;
   logic [1:0]            sel_q;
   logic                  locked_q;
   logic                  error_q;
   logic                  timeout_q;

   logic                  pulse;
   logic                  hit;
   logic [1:0]            code;
   logic [1:0]            cand_d;
   logic [MCW-1:0]        match_d;

   assign pulse = bus.i_valid;

   // Classify the period ending at this pulse; the priority chain resolves
   // duplicate thresholds to the lowest code.
   always_comb begin
      hit  = 1'b1;
      code = 2'd0;
      if (cnt_q == EXP0) begin
         code = 2'd0;
      end else if (cnt_q == EXP1) begin
         code = 2'd1;
      end else if (cnt_q == EXP2) begin
         code = 2'd2;
      end else if (cnt_q == EXP3) begin
         code = 2'd3;
      end else begin
         hit = 1'b0;
      end
   end

   // Run-length of consecutive identical codes while acquiring. A run only
   // extends when one is already in progress (match_q != 0); after a "none"
   // period the same code starts a fresh run.
   always_comb begin
      cand_d  = cand_q;
      match_d = '0;
      if (hit) begin
         if (code == cand_q && match_q != '0) begin
            match_d = match_q + MCW'(1);
         end else begin
            cand_d  = code;
            match_d = MCW'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (i_reset) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         cand_q         <= '0;
         match_q        <= '0;
         period_q       <= '0;
         period_valid_q <= 1'b0;
         sel_q          <= '0;
         locked_q       <= 1'b0;
         error_q        <= 1'b0;
         timeout_q      <= 1'b0;
      end else begin
         period_valid_q <= 1'b0;
         error_q        <= 1'b0;
         timeout_q      <= 1'b0;

         case (state_q)
            // Counter frozen; the first pulse only starts timing, no period exists yet.
            IDLE: begin
               if (pulse) begin
                  cnt_q   <= DATA_WIDTH'(1);
                  cand_q  <= '0;
                  match_q <= '0;
                  state_q <= MEASURE;
               end
            end

            MEASURE: begin
               if (pulse) begin
                  cnt_q          <= DATA_WIDTH'(1);
                  period_q       <= cnt_q;
                  period_valid_q <= 1'b1;
                  cand_q         <= cand_d;
                  match_q        <= match_d;
                  if (match_d >= LOCK_N) begin
                     state_q  <= LOCKED;
                     sel_q    <= cand_d;
                     locked_q <= 1'b1;
                  end
               end else if (cnt_q == TLIMIT) begin
                  timeout_q <= 1'b1;
                  locked_q  <= 1'b0;
                  match_q   <= '0;
                  state_q   <= IDLE;
               end else begin
                  cnt_q <= cnt_q + DATA_WIDTH'(1);
               end
            end

            LOCKED: begin
               if (pulse) begin
                  cnt_q          <= DATA_WIDTH'(1);
                  period_q       <= cnt_q;
                  period_valid_q <= 1'b1;
                  if (!(hit && code == sel_q)) begin
                     // Lock lost: the offending period seeds the next acquisition,
                     // while o_sel keeps reporting the code that was locked.
                     error_q  <= 1'b1;
                     locked_q <= 1'b0;
                     state_q  <= MEASURE;
                     if (hit) begin
                        cand_q  <= code;
                        match_q <= MCW'(1);
                     end else begin
                        match_q <= '0;
                     end
                  end
               end else if (cnt_q == TLIMIT) begin
                  timeout_q <= 1'b1;
                  locked_q  <= 1'b0;
                  match_q   <= '0;
                  state_q   <= IDLE;
               end else begin
                  cnt_q <= cnt_q + DATA_WIDTH'(1);
               end
            end

            default: begin
               state_q  <= IDLE;
               locked_q <= 1'b0;
               match_q  <= '0;
            end
         endcase
      end
   end

   assign bus.o_period       = period_q;
   assign bus.o_period_valid = period_valid_q;
   assign bus.o_sel          = sel_q;
   assign bus.o_locked       = locked_q;
   assign bus.o_error        = error_q;
   assign bus.o_timeout      = timeout_q;

endmodule

// File: tb/tb_period_decoder.sv
// Bench for period_decoder: table of pulse gaps with hand-derived results, timeout and reset
// sequences, then random pulse trains, all cross-checked every cycle against a gap-based model.
module tb_period_decoder;

   localparam int DW     = 32;
   localparam int OFF    = 1;
   localparam int LC     = 4;
   localparam int TLIMIT = 5001;
   localparam int THR [4] = '{3, 10, 100, 5000};

   logic clock = 1'b0;
   logic i_reset;
   always #5 clock = ~clock;

   period_decoder_if #(.DATA_WIDTH(DW)) bus ();

   period_decoder #(
      .DATA_WIDTH(DW), .R0(3), .R1(10), .R2(100), .R3(5000),
      .PERIOD_OFFSET(OFF), .LOCK_COUNT(LC)
   ) dut (
      .clock   (clock),
      .i_reset (i_reset),
      .bus     (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: works on absolute pulse times and a history of codes.
   int   t = 0;
   bit   m_active;
   int   m_last;
   int   m_period;
   int   m_sel;
   bit   m_locked, m_pv, m_err, m_to;
   int   m_codes[$];

   typedef struct {
      int gap;
      bit pv;
      int period;
      bit locked;
      int sel;
      bit err;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, t);
      end
   endtask

   function automatic int classify(input int g);
      for (int k = 0; k < 4; k++)
         if (g == THR[k] + OFF) return k;
      return -1;
   endfunction

   // Locked when the most recent LC codes since acquisition started are one real code.
   function automatic bit run_ok();
      int last;
      if (m_codes.size() < LC) return 1'b0;
      last = m_codes[m_codes.size()-1];
      if (last < 0) return 1'b0;
      for (int i = m_codes.size() - LC; i < m_codes.size(); i++)
         if (m_codes[i] != last) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_step(input bit v, input bit rst);
      int gap, code;
      m_pv = 0; m_err = 0; m_to = 0;
      if (rst) begin
         m_active = 0; m_locked = 0; m_sel = 0; m_period = 0;
         m_codes.delete();
      end else if (!m_active) begin
         if (v) begin
            m_active = 1; m_last = t;
            m_codes.delete();
         end
      end else begin
         gap = t - m_last;
         if (v) begin
            code = classify(gap);
            m_period = gap; m_pv = 1; m_last = t;
            if (m_locked) begin
               if (code != m_sel) begin
                  m_err = 1; m_locked = 0;
                  m_codes.delete();
                  m_codes.push_back(code);
               end
            end else begin
               m_codes.push_back(code);
               if (run_ok()) begin
                  m_locked = 1; m_sel = code;
               end
            end
         end else if (gap == TLIMIT) begin
            m_to = 1; m_locked = 0; m_active = 0;
         end
      end
   endtask

   task automatic cycle(input logic v, input logic rst);
      logic [37:0] act, exp;
      bus.i_valid = v;
      i_reset     = rst;
      model_step(v, rst);
      @(posedge clock);
      #1;
      t++;
      act = {bus.o_period, bus.o_period_valid, bus.o_sel, bus.o_locked, bus.o_error, bus.o_timeout};
      exp = {32'(m_period), m_pv, 2'(m_sel), m_locked, m_err, m_to};
      check("outputs_vs_model", 64'(act), 64'(exp));
   endtask

   task automatic pulse_after(input int g);
      for (int i = 1; i < g; i++) cycle(1'b0, 1'b0);
      cycle(1'b1, 1'b0);
   endtask

   initial begin
      int seen, g, r, big;

      // gap, pv, period, locked, sel, err  (row 0 is the first pulse out of reset)
      tbl.push_back('{3,    0, 0,    0, 0, 0});
      tbl.push_back('{4,    1, 4,    0, 0, 0});
      tbl.push_back('{4,    1, 4,    0, 0, 0});
      tbl.push_back('{4,    1, 4,    0, 0, 0});
      tbl.push_back('{4,    1, 4,    1, 0, 0});
      tbl.push_back('{4,    1, 4,    1, 0, 0});
      tbl.push_back('{11,   1, 11,   0, 0, 1});
      tbl.push_back('{11,   1, 11,   0, 0, 0});
      tbl.push_back('{11,   1, 11,   0, 0, 0});
      tbl.push_back('{11,   1, 11,   1, 1, 0});
      tbl.push_back('{11,   1, 11,   1, 1, 0});
      tbl.push_back('{7,    1, 7,    0, 1, 1});
      tbl.push_back('{7,    1, 7,    0, 1, 0});
      tbl.push_back('{1,    1, 1,    0, 1, 0});
      tbl.push_back('{101,  1, 101,  0, 1, 0});
      tbl.push_back('{1,    1, 1,    0, 1, 0});
      tbl.push_back('{101,  1, 101,  0, 1, 0});
      tbl.push_back('{101,  1, 101,  0, 1, 0});
      tbl.push_back('{101,  1, 101,  0, 1, 0});
      tbl.push_back('{101,  1, 101,  1, 2, 0});
      tbl.push_back('{5001, 1, 5001, 0, 2, 1});
      tbl.push_back('{5001, 1, 5001, 0, 2, 0});
      tbl.push_back('{5001, 1, 5001, 0, 2, 0});
      tbl.push_back('{5001, 1, 5001, 1, 3, 0});

      bus.i_valid = 1'b0;
      i_reset     = 1'b1;
      cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b1);
      check("reset_period",  bus.o_period, 0);
      check("reset_pvalid",  bus.o_period_valid, 0);
      check("reset_sel",     bus.o_sel, 0);
      check("reset_locked",  bus.o_locked, 0);
      check("reset_error",   bus.o_error, 0);
      check("reset_timeout", bus.o_timeout, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         pulse_after(tbl[i].gap);
         check($sformatf("tbl%0d_pvalid", i), bus.o_period_valid, tbl[i].pv);
         check($sformatf("tbl%0d_period", i), bus.o_period, tbl[i].period);
         check($sformatf("tbl%0d_locked", i), bus.o_locked, tbl[i].locked);
         check($sformatf("tbl%0d_sel", i),    bus.o_sel, tbl[i].sel);
         check($sformatf("tbl%0d_error", i),  bus.o_error, tbl[i].err);
      end

      // Timeout: pulses stop while locked on code 3.
      seen = 0;
      for (int i = 1; i <= 6000 && seen == 0; i++) begin
         cycle(1'b0, 1'b0);
         if (bus.o_timeout) seen = i;
      end
      check("timeout_delay",  seen, TLIMIT);
      check("timeout_locked", bus.o_locked, 0);
      check("timeout_sel",    bus.o_sel, 3);
      check("timeout_period", bus.o_period, 5001);
      cycle(1'b0, 1'b0);
      check("timeout_one_cycle", bus.o_timeout, 0);
      pulse_after(2);
      check("idle_restart_pvalid", bus.o_period_valid, 0);
      pulse_after(4);
      check("after_restart_pvalid", bus.o_period_valid, 1);
      check("after_restart_period", bus.o_period, 4);

      // Reset while locked.
      pulse_after(4);
      pulse_after(4);
      pulse_after(4);
      check("prereset_locked", bus.o_locked, 1);
      cycle(1'b0, 1'b1);
      check("midreset_period", bus.o_period, 0);
      check("midreset_locked", bus.o_locked, 0);
      check("midreset_sel",    bus.o_sel, 0);
      pulse_after(2);
      check("postreset_first_pvalid", bus.o_period_valid, 0);
      pulse_after(4);
      check("postreset_pvalid", bus.o_period_valid, 1);
      check("postreset_locked", bus.o_locked, 0);

      // Random pulse trains; repeats of the previous gap make locks likely.
      g = 4;
      big = 0;
      for (int n = 0; n < 250; n++) begin
         r = $urandom_range(0, 99);
         if (r < 45) begin
            g = g;
         end else if (r < 80) begin
            case ($urandom_range(0, 6))
               0: g = 1;
               1: g = 4;
               2: g = 11;
               3: g = 101;
               4: g = 7;
               5: g = 2;
               default: g = 5;
            endcase
         end else if (r < 97) begin
            g = $urandom_range(1, 30);
         end else begin
            g = ($urandom_range(0, 1) == 0) ? 5001 : $urandom_range(5002, 5010);
         end
         if (g > 200) begin
            if (big >= 4) g = 4;
            else big++;
         end
         if ($urandom_range(0, 99) == 0) cycle(1'b0, 1'b1);
         pulse_after(g);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/period_decoder.md
Name: period_decoder

Overview:
- Receives the single-cycle pulse train produced by the programmable tick generator and measures the distance between pulses in clock cycles.
- Recovers which of the four period thresholds (R0..R3) the generator is set to, which is the 2-bit switch selection.
- Declares lock after LOCK_COUNT consecutive matching periods.
- Reports loss of lock and pulse timeout. It sits at the receiving end of the generator's o_valid line.

Parameters:
- DATA_WIDTH, 32, width of the period counter and of o_period.
- R0, 3, threshold for code 0.
- R1, 10, threshold for code 1.
- R2, 100, threshold for code 2.
- R3, 5000, threshold for code 3.
- PERIOD_OFFSET, 1, expected period for code k is Rk+PERIOD_OFFSET.
- LOCK_COUNT, 4, number of consecutive same-code periods required to lock (>=1).

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- i_reset  input  1  synchronous reset, active-high.
- i_valid  input  1  pulse train from the generator; each high cycle is one pulse.
- o_period  output  DATA_WIDTH  last measured period in cycles.
- o_period_valid  output  1  one-cycle strobe when o_period updates.
- o_sel  output  2  decoded code of the current or last lock.
- o_locked  output  1  high while locked.
- o_error  output  1  one-cycle strobe on loss of lock due to a mismatching period.
- o_timeout  output  1  one-cycle strobe when pulses stop.

Behaviour:
- Reset (sync, i_reset=1 at the edge):
  - State goes to IDLE; cnt=0, cand=0, match_cnt=0.
  - All outputs go to 0.
  - Reset mid-operation discards any lock and any partial measurement.
- Derived constant TLIMIT = max(R0..R3)+PERIOD_OFFSET. It must fit in DATA_WIDTH.
- Period measurement:
  - On each pulse cycle, cnt reloads to 1; on every other non-IDLE cycle, cnt increments.
  - At a pulse outside IDLE, the period is P=cnt. Example: pulses at cycles 0 and 4 give P=4.
  - At the edge of the pulse cycle, o_period<=P and o_period_valid<=1 for one cycle. Latency is one cycle.
- Classification:
  - The code is the lowest k with P==Rk+PERIOD_OFFSET.
  - If no k matches, the result is "none". Duplicate thresholds resolve to the lowest index.
- States:
  - IDLE: the counter is frozen. The first pulse gives cnt=1 and a transition to MEASURE. No period is reported.
  - MEASURE, on a pulse:
    - Code k with k==cand and match_cnt>0: match_cnt++.
    - Other code k: cand=k, match_cnt=1.
    - "none": match_cnt=0.
    - If the new match_cnt==LOCK_COUNT: go to LOCKED, o_sel<=cand, o_locked<=1 on the same edge as o_period_valid.
  - LOCKED, on a pulse:
    - Code==o_sel: stay.
    - Otherwise: o_error pulse, o_locked<=0, go to MEASURE. cand and match_cnt are reloaded from this period (1 if it matched a code, else 0).
    - o_sel holds its last locked value after loss of lock.
- Timeout:
  - Fires in MEASURE or LOCKED when cnt==TLIMIT and i_valid==0 in the same cycle.
  - Effect: o_timeout pulse, o_locked<=0, match_cnt=0, go to IDLE, o_period unchanged.
  - A pulse arriving exactly when cnt==TLIMIT takes priority and is measured normally (P=TLIMIT, a valid code 3 match at defaults).
- Back-to-back pulses give P=1, which is classified normally.
- A strobe is never held for more than one cycle. o_error and o_timeout never assert in the same cycle.

Test Plan:
- Defaults; i_valid pulses every 4 cycles, 5 pulses:
  - o_period_valid 4 times, each with o_period=4.
  - o_locked=1 and o_sel=0 on the edge after the 5th pulse; o_error=0.
- Locked on code 0, then 5 pulses spaced 11 cycles:
  - o_error pulses once after the first 11-cycle period and o_locked drops.
  - After the 4th 11-cycle period, o_locked=1 and o_sel=1.
- Pulses every 7 cycles, 10 pulses:
  - o_period=7 each time.
  - o_locked stays 0; o_error=0; o_timeout=0.
- Locked on code 0, then i_valid held low:
  - o_timeout pulses exactly when cnt reaches 5001, i.e. 5000 cycles after the last pulse edge.
  - o_locked=0; the next pulse produces no o_period_valid (IDLE restart).
- Locked, then i_reset=1 for one cycle:
  - All outputs are 0 the following cycle.
  - The next pulse is treated as the first pulse, so no period is reported.
- Two adjacent pulses after the first: o_period=1, code none, match_cnt=0, no lock.
